// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: FSM states, instruction classes,
// ALU operation codes and RV32 opcode/funct7 values.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_TRAP = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_LOAD,
        C_STORE,
        C_RTYPE,
        C_ITYPE,
        C_BEQ,
        C_BNE
    } iclass_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder: classifies the IR, selects the ALU operation
// and flags anything outside the supported instruction subset as illegal.
module instr_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int EN_BRANCH = 1
) (
    input  logic [31:0] ir,
    output logic [3:0]  alu_ctrl,
    output iclass_t     cls,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always_comb begin
        alu_ctrl = '0;
        cls      = C_NONE;
        legal    = 1'b0;
        case (opcode)
            OP_LOAD, OP_STORE: begin
                if (funct3 == 3'b010) begin
                    alu_ctrl = ALU_ADD;
                    cls      = (opcode == OP_LOAD) ? C_LOAD : C_STORE;
                    legal    = 1'b1;
                end
            end
            OP_RTYPE: begin
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
                    {F7_ALT,  3'b000}: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
                    {F7_BASE, 3'b111}: begin alu_ctrl = ALU_AND; legal = 1'b1; end
                    {F7_BASE, 3'b110}: begin alu_ctrl = ALU_OR;  legal = 1'b1; end
                    {F7_BASE, 3'b100}: begin alu_ctrl = ALU_XOR; legal = 1'b1; end
                    {F7_BASE, 3'b010}: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
                    {F7_BASE, 3'b001}: begin alu_ctrl = ALU_SLL; legal = 1'b1; end
                    {F7_BASE, 3'b101}: begin alu_ctrl = ALU_SRL; legal = 1'b1; end
                    {F7_ALT,  3'b101}: begin alu_ctrl = ALU_SRA; legal = 1'b1; end
                    default: ;
                endcase
                if (legal) cls = C_RTYPE;
            end
            OP_ITYPE: begin
                case (funct3)
                    3'b000: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
                    3'b111: begin alu_ctrl = ALU_AND; legal = 1'b1; end
                    3'b110: begin alu_ctrl = ALU_OR;  legal = 1'b1; end
                    3'b100: begin alu_ctrl = ALU_XOR; legal = 1'b1; end
                    3'b010: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
                    3'b001: begin alu_ctrl = ALU_SLL; legal = 1'b1; end
                    3'b101: begin
                        // Shift-right immediates carry the arithmetic/logical select in funct7
                        if (funct7 == F7_BASE) begin
                            alu_ctrl = ALU_SRL;
                            legal    = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            alu_ctrl = ALU_SRA;
                            legal    = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (legal) cls = C_ITYPE;
            end
            OP_BRANCH: begin
                if (EN_BRANCH != 0 && (funct3 == 3'b000 || funct3 == 3'b001)) begin
                    alu_ctrl = ALU_SUB;
                    cls      = (funct3 == 3'b000) ? C_BEQ : C_BNE;
                    legal    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch, decode, execute, optional memory wait with timeout,
// write-back, and a sticky trap state for illegal instructions or memory timeouts.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_W    = 4,
    parameter int EN_BRANCH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        iReady,
    input  logic        dReady,
    input  logic        zero,
    output logic        iReq,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        loadPC,
    output logic        PCSrc,
    output logic [3:0]  ALUCtrl,
    output logic [2:0]  current_state,
    output logic        illegal,
    output logic        timeout
);

    // Counter value whose increment would reach the all-ones timeout limit
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((1 << WAIT_W) - 2);

    state_t            state;
    logic [31:0]       ir;
    logic              zero_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic [3:0] dec_alu;
    iclass_t    dec_cls;
    logic       dec_legal;
    logic       is_mem;
    logic       in_exec;

    instr_decode #(.EN_BRANCH(EN_BRANCH)) u_decode (
        .ir      (ir),
        .alu_ctrl(dec_alu),
        .cls     (dec_cls),
        .legal   (dec_legal)
    );

    assign is_mem = (dec_cls == C_LOAD) || (dec_cls == C_STORE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IF;
            ir       <= '0;
            zero_q   <= 1'b0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IF: begin
                    if (iReady) begin
                        ir    <= instr;
                        state <= S_ID;
                    end
                end
                S_ID: begin
                    if (dec_legal) begin
                        state <= S_EX;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_TRAP;
                    end
                end
                S_EX: begin
                    zero_q   <= zero;
                    wait_cnt <= '0;
                    state    <= is_mem ? S_MEM : S_WB;
                end
                S_MEM: begin
                    // Completion wins over timeout when both land on the same cycle
                    if (dReady) begin
                        state <= S_WB;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            timeout <= 1'b1;
                            state   <= S_TRAP;
                        end
                    end
                end
                S_WB:    state <= S_IF;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    assign current_state = state;

    always_comb begin
        in_exec  = dec_legal && (state == S_ID || state == S_EX || state == S_MEM || state == S_WB);
        iReq     = (state == S_IF);
        ALUCtrl  = in_exec ? dec_alu : '0;
        ALUSrc   = in_exec && (is_mem || dec_cls == C_ITYPE);
        MemtoReg = in_exec && (dec_cls == C_LOAD);
        MemRead  = (state == S_MEM) && (dec_cls == C_LOAD);
        MemWrite = (state == S_MEM) && (dec_cls == C_STORE);
        RegWrite = (state == S_WB) &&
                   (dec_cls == C_LOAD || dec_cls == C_RTYPE || dec_cls == C_ITYPE);
        loadPC   = (state == S_WB);
        PCSrc    = (state == S_WB) &&
                   ((dec_cls == C_BEQ && zero_q) || (dec_cls == C_BNE && !zero_q));
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by random
// instructions, checked cycle by cycle against a table-driven reference model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        iReady, dReady, zero;
    logic        iReq, MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, loadPC, PCSrc;
    logic [3:0]  ALUCtrl;
    logic [2:0]  current_state;
    logic        illegal, timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_W(4), .EN_BRANCH(1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .iReady(iReady), .dReady(dReady), .zero(zero),
        .iReq(iReq), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .loadPC(loadPC), .PCSrc(PCSrc),
        .ALUCtrl(ALUCtrl), .current_state(current_state), .illegal(illegal), .timeout(timeout)
    );

    logic [16:0] obs;
    assign obs = {current_state, iReq, MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg,
                  loadPC, PCSrc, ALUCtrl, illegal, timeout};

    // Reference decode: kind 0 illegal, 1 load, 2 store, 3 R, 4 I, 5 beq, 6 bne
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  alu;
        int          kind;
    } pat_t;
    pat_t pats[$];

    task automatic add_pat(input logic [31:0] m, input logic [31:0] v, input logic [3:0] a, input int k);
        pat_t p;
        p.mask = m; p.match = v; p.alu = a; p.kind = k;
        pats.push_back(p);
    endtask

    task automatic build_table();
        add_pat(32'hFE00707F, 32'h00000033, 4'b0010, 3);
        add_pat(32'hFE00707F, 32'h40000033, 4'b0110, 3);
        add_pat(32'hFE00707F, 32'h00007033, 4'b0000, 3);
        add_pat(32'hFE00707F, 32'h00006033, 4'b0001, 3);
        add_pat(32'hFE00707F, 32'h00004033, 4'b0101, 3);
        add_pat(32'hFE00707F, 32'h00002033, 4'b0100, 3);
        add_pat(32'hFE00707F, 32'h00001033, 4'b1001, 3);
        add_pat(32'hFE00707F, 32'h00005033, 4'b1000, 3);
        add_pat(32'hFE00707F, 32'h40005033, 4'b1010, 3);
        add_pat(32'h0000707F, 32'h00000013, 4'b0010, 4);
        add_pat(32'h0000707F, 32'h00007013, 4'b0000, 4);
        add_pat(32'h0000707F, 32'h00006013, 4'b0001, 4);
        add_pat(32'h0000707F, 32'h00004013, 4'b0101, 4);
        add_pat(32'h0000707F, 32'h00002013, 4'b0100, 4);
        add_pat(32'h0000707F, 32'h00001013, 4'b1001, 4);
        add_pat(32'hFE00707F, 32'h00005013, 4'b1000, 4);
        add_pat(32'hFE00707F, 32'h40005013, 4'b1010, 4);
        add_pat(32'h0000707F, 32'h00002003, 4'b0010, 1);
        add_pat(32'h0000707F, 32'h00002023, 4'b0010, 2);
        add_pat(32'h0000707F, 32'h00000063, 4'b0110, 5);
        add_pat(32'h0000707F, 32'h00001063, 4'b0110, 6);
    endtask

    task automatic ref_decode(input logic [31:0] w, output int kind, output logic [3:0] alu);
        kind = 0;
        alu  = 4'b0000;
        foreach (pats[i]) begin
            if ((w & pats[i].mask) == pats[i].match) begin
                kind = pats[i].kind;
                alu  = pats[i].alu;
            end
        end
    endtask

    function automatic logic [16:0] ev(input logic [2:0] st, input logic rq, input logic mr,
                                       input logic mw, input logic rw, input logic as,
                                       input logic mt, input logic lp, input logic pc,
                                       input logic [3:0] alu, input logic il, input logic to);
        return {st, rq, mr, mw, rw, as, mt, lp, pc, alu, il, to};
    endfunction

    task automatic chk(input string tag, input logic [16:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0; iReady = 1'b0; dReady = 1'b0;
        #1;
        chk({nm, "/rst_async"}, ev(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        step();
        chk({nm, "/rst_hold"}, ev(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        rst = 1'b1;
    endtask

    // wt: 0-based MEM cycle on which dReady is raised; 15 or more never completes
    task automatic run_instr(input logic [31:0] w, input int idle, input int wt,
                             input logic z, input string nm);
        int kind;
        logic [3:0] a;
        logic asrc, mtr, rw, pc;
        ref_decode(w, kind, a);
        iReady = 1'b0;
        instr  = $urandom;
        for (int i = 0; i < idle; i++) begin
            chk({nm, "/if_wait"}, ev(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
            step();
        end
        instr = w; iReady = 1'b1;
        chk({nm, "/if"}, ev(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        step();
        iReady = 1'b0; instr = $urandom;
        if (kind == 0) begin
            chk({nm, "/id_illegal"}, ev(3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
            step();
            chk({nm, "/trap_illegal"}, ev(3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
            step();
            chk({nm, "/trap_stays"}, ev(3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
            do_reset(nm);
            return;
        end
        asrc = (kind == 1 || kind == 2 || kind == 4);
        mtr  = (kind == 1);
        chk({nm, "/id"}, ev(3'b001, 0, 0, 0, 0, asrc, mtr, 0, 0, a, 0, 0));
        step();
        zero = z;
        chk({nm, "/ex"}, ev(3'b010, 0, 0, 0, 0, asrc, mtr, 0, 0, a, 0, 0));
        step();
        zero = 1'($urandom);
        if (kind == 1 || kind == 2) begin
            for (int k = 0; k < 16; k++) begin
                dReady = (k == wt);
                chk({nm, "/mem"}, ev(3'b011, 0, kind == 1, kind == 2, 0, asrc, mtr, 0, 0, a, 0, 0));
                step();
                dReady = 1'b0;
                if (k == wt) break;
                if (k == 14) begin
                    chk({nm, "/timeout"}, ev(3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1));
                    do_reset(nm);
                    return;
                end
            end
        end
        rw = (kind == 1 || kind == 3 || kind == 4);
        pc = (kind == 5 && z) || (kind == 6 && !z);
        chk({nm, "/wb"}, ev(3'b100, 0, 0, 0, rw, asrc, mtr, 1, pc, a, 0, 0));
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = int'($urandom_range(0, 7));
        case (k)
            0, 1: begin
                w[6:0] = (k == 0) ? 7'b0000011 : 7'b0100011;
                if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010;
            end
            2, 7: begin
                w[6:0]   = 7'b0110011;
                w[31:25] = ($urandom_range(0, 3) == 0) ? 7'b0100000 : 7'b0000000;
            end
            3: begin
                w[6:0] = 7'b0010011;
                if ($urandom_range(0, 2) != 0)
                    w[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0100000 : 7'b0000000;
            end
            4: begin
                w[6:0]   = 7'b1100011;
                w[14:12] = 3'($urandom_range(0, 2));
            end
            default: ;
        endcase
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b001) w[31:25] = 7'b0000000;
        return w;
    endfunction

    initial begin
        int wt;
        build_table();
        rst = 1'b0; instr = '0; iReady = 1'b0; dReady = 1'b0; zero = 1'b0;
        #1;
        chk("reset", ev(3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
        step();
        step();
        rst = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0, "add");
        run_instr(32'h0080A283, 1, 3, 1'b0, "lw_wait3");
        run_instr(32'h00208463, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00208463, 0, 0, 1'b0, "beq_not");
        run_instr(32'h00209463, 0, 0, 1'b0, "bne_taken");
        run_instr(32'h4020D193, 0, 0, 1'b0, "srai");
        run_instr(32'h6020D193, 0, 0, 1'b0, "srai_bad_f7");
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, "all_ones");
        run_instr(32'h0020A023, 0, 99, 1'b0, "sw_timeout");
        run_instr(32'h0080A283, 0, 14, 1'b0, "lw_last_cycle");
        run_instr(32'h0020A023, 2, 0, 1'b0, "sw_fast");

        // Reset mid-MEM must drop MemRead without a clock edge
        instr = 32'h0080A283; iReady = 1'b1;
        step();
        iReady = 1'b0;
        step();
        step();
        chk("midmem/mem", ev(3'b011, 0, 1, 0, 0, 1, 1, 0, 0, 4'b0010, 0, 0));
        do_reset("midmem");

        for (int n = 0; n < 60; n++) begin
            wt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 16))
                                              : int'($urandom_range(0, 3));
            run_instr(rand_instr(), int'($urandom_range(0, 2)), wt, 1'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_W, default 4: width of the memory wait counter; the timeout limit is 2^WAIT_W-1 cycles.
REQ-002 Parameter EN_BRANCH, default 1: 1 decodes BEQ/BNE; 0 treats opcode 1100011 as illegal.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 instr  in  32  fetched instruction word, valid when iReady=1.
REQ-006 iReady  in  1  instruction memory has the word ready.
REQ-007 dReady  in  1  data memory has completed the access.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 iReq  out  1  instruction fetch request.
REQ-010 MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, loadPC, PCSrc  out  1 each  datapath controls.
REQ-011 ALUCtrl  out  4  ALU operation code.
REQ-012 current_state  out  3  FSM state, for monitoring.
REQ-013 illegal, timeout  out  1 each  sticky trap causes.

Function
REQ-014 The FSM SHALL have states IF=000, ID=001, EX=010, MEM=011, WB=100, TRAP=101; encodings 110 and 111 go to TRAP.
REQ-015 In IF: iReq=1; on iReady=1 latch instr into an internal IR and go to ID; otherwise remain in IF; no timeout in IF.
REQ-016 In ID: decode the IR; legal opcodes go to EX, illegal ones set illegal=1 and go to TRAP.
REQ-017 Legal set: load 0000011 (funct3 010), store 0100011 (funct3 010), R-type 0110011, I-type ALU 0010011, branch 1100011 (funct3 000/001, EN_BRANCH=1 only).
REQ-018 R-type ALUCtrl: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0101, SLT 0100, SLL 1001, SRL 1000, SRA 1010; any other funct7/funct3 pair is illegal.
REQ-019 I-type ALUCtrl uses the same codes; SRLI/SRAI require funct7 0000000/0100000, otherwise illegal; ALUSrc=1.
REQ-020 Load/store: ALUCtrl=ADD and ALUSrc=1; branch: ALUCtrl=SUB and ALUSrc=0.
REQ-021 ALUCtrl, ALUSrc and MemtoReg SHALL be driven from the IR and held stable from ID through WB.
REQ-022 In EX: sample zero into zero_q; load/store go to MEM, all others go to WB.
REQ-023 In MEM: hold MemRead (load) or MemWrite (store) high until the cycle dReady=1, then go to WB.
REQ-024 The wait counter clears on MEM entry and increments each MEM cycle with dReady=0.
REQ-025 When the counter reaches 2^WAIT_W-1 with dReady still 0, set timeout=1 and go to TRAP.
REQ-026 dReady=1 in the same cycle the counter reaches its limit counts as completion, not timeout.
REQ-027 In WB: RegWrite=1 for load, R-type and I-type; MemtoReg=1 for load.
REQ-028 In WB: loadPC=1 for exactly one cycle for every instruction.
REQ-029 In WB: PCSrc=1 when (BEQ and zero_q) or (BNE and !zero_q); then go to IF.
REQ-030 In TRAP: all datapath controls and iReq are 0; the FSM stays in TRAP until reset.
REQ-031 All outputs not stated above SHALL be 0.
REQ-032 Minimum latency with zero wait cycles: 4 cycles for R-type, I-type and branch; 5 cycles for load and store.

Reset
REQ-033 While rst=0: current_state=IF, IR=0, zero_q=0, counter=0, illegal=0, timeout=0.
REQ-034 While rst=0, all combinational outputs SHALL follow IF with iReq=1.
REQ-035 Reset asserted mid-MEM SHALL drop MemRead/MemWrite immediately, with no clock edge required.

Structure
REQ-036 ALU codes, state encodings and opcode constants SHALL live in a shared package, reused by datapath and top level.
REQ-037 Decode SHALL be a combinational sub-module, instr_decode: IR in; ALUCtrl, class and legal out.

Verification
REQ-038 Scenario: instr=0x002081B3 (add), iReady=1 -> states IF,ID,EX,WB; ALUCtrl=0010; RegWrite=1 and loadPC=1 in WB only.
REQ-039 Scenario: instr=0x0080A283 (lw), dReady low 3 cycles -> MemRead high 4 MEM cycles, then WB with RegWrite=1 and MemtoReg=1.
REQ-040 Scenario: instr=0x00208463 (beq), zero=1 in EX -> PCSrc=1 with loadPC=1 in WB; zero=0 gives PCSrc=0.
REQ-041 Scenario: instr=0xFFFFFFFF -> ID then TRAP, illegal=1, all controls 0; then rst=0 gives IF with illegal=0.
REQ-042 Scenario: store, WAIT_W=4, dReady never high -> timeout=1 after 15 MEM cycles; MemWrite=0 in TRAP.
REQ-043 Scenario: load with dReady=1 on the 15th MEM cycle -> WB, timeout=0.
